uart_rx_recovery: RTL and testbench
===================================

// Module: uart_rx_recovery
// PURPOSE
//  Parametrised UART receive front end for uart_lite; successor to the fixed-format character recovery.
//  Oversampled (one clk_i per sample) serial rx in, framed characters out through a valid/ready holding register.
//  Adds: runtime word length, parity and stop-bit count; 3-sample majority vote; input synchroniser;
//  break detection; overrun reporting. Sits between the rx pad and the uart_lite rx FIFO.
// PARAMETERS
//  OVERSAMPLING   16  clocks per bit period, >= 8
//  MAX_DATA_BITS  9   widest supported word, 5..9
//  SYNC_STAGES    2   rx_i synchroniser depth, >= 2
// PORTS
//  clk_i           in   1                 the single clock
//  rst_ni          in   1                 reset, asynchronous assert, active-low
//  rx_i            in   1                 asynchronous serial line, idle high
//  data_bits_i     in   4                 word length; <5 is treated as 5, >MAX_DATA_BITS as MAX_DATA_BITS
//  parity_mode_i   in   3                 0 none, 1 even, 2 odd, 3 mark(1), 4 space(0); 5..7 = none
//  stop_bits_i     in   1                 0: one stop bit, 1: two stop bits
//  char_o          out  MAX_DATA_BITS     received word, LSB first on line, unused MSBs zero
//  valid_o         out  1                 char_o and error flags are valid
//  ready_i         in   1                 consumer accepts; transfer when valid_o && ready_i
//  frame_error_o   out  1                 qualified by valid_o: a stop bit sampled low
//  parity_error_o  out  1                 qualified by valid_o: parity mismatch
//  overrun_o       out  1                 1-cycle pulse: frame completed while holding register full
//  break_o         out  1                 1-cycle pulse: break condition detected
//  busy_o          out  1                 state != IDLE
// BEHAVIOUR
//  Reset (rst_ni low, asynchronous): all outputs 0, char_o 0, state IDLE, synchroniser and history regs 1.
//  rx_i passes through SYNC_STAGES flops -> rx_s; a 3-bit history keeps the last three rx_s values.
//  Bit decision = majority of the history at the mid tick, i.e. samples at mid-2, mid-1 and mid.
//  Tick counter: loaded OVERSAMPLING/2-1 on start edge, OVERSAMPLING-1 on each later mid tick.
//  mid tick = counter == 0.
//  Config (data_bits_i, parity_mode_i, stop_bits_i) is latched on start edge; mid-frame changes ignored.
//  FSM:
//   IDLE       -> START on falling edge of rx_s (previous 1, current 0).
//   START      mid tick: majority 0 -> DATA; 1 -> IDLE (glitch rejected, no flags).
//   DATA       mid tick: shift bit into char[index]; after the last bit -> PARITY if enabled, else STOP.
//   PARITY     mid tick: even/odd compare against XOR of data; mark/space compare against the constant -> STOP.
//   STOP       one mid tick per stop bit; any stop bit sampled 0 sets frame error; after the last one -> IDLE.
//   BREAK_WAIT entered instead of delivery when start, all data, parity and all stop bits sampled 0;
//              break_o pulses, no character is delivered; -> IDLE only after rx_s has been 1 for one full bit period.
//  Delivery: the cycle after the last stop mid tick, unless break.
//   If the holding register is empty, or valid_o && ready_i in the same cycle: load char_o and flags, valid_o=1.
//   Otherwise: overrun_o pulses, the new word is dropped and the held word/flags are unchanged.
//  Characters with frame or parity errors are still delivered, with their flags set.
//  valid_o clears on a valid_o && ready_i transfer with no simultaneous load; the flags clear with it.
//  valid_o && !ready_i: char_o and flags remain stable.
//  Latency: valid_o rises 1 clk after the final stop-bit mid tick.
//  IDLE re-arms immediately: a start edge right after the stop mid tick is accepted (back-to-back frames).
//  Reset mid-frame: immediate return to IDLE; a held character is discarded.
// STRUCTURE
//  uart_lite_defs.vh: state encodings, parity-mode encodings, data_bits clamp limits.
//  Sub-module uart_rx_sync_filter: synchroniser + 3-bit history + majority vote + falling-edge detect.
//  This module holds the FSM, tick counter, shift/parity logic and holding register.
// TESTING  (OVERSAMPLING=16, 1 bit = 16 clk)
//  8N1 byte 0xA5, ready_i=1 -> valid_o 1 cycle, char_o=0x0A5, both error flags 0.
//  7E2 0x41, parity bit flipped -> char_o=0x041, parity_error_o=1, valid_o=1; 2nd stop low -> frame_error_o=1.
//  1-clk and 2-clk low pulses on an idle line, plus a 1-clk glitch mid-bit -> no valid_o, decoded value unchanged.
//  Two back-to-back 8N1 frames 0x11, 0x22 with ready_i=0 -> char_o stays 0x011, overrun_o one pulse.
//  Then ready_i=1 -> 0x011 transferred, line idle, valid_o falls.
//  Line low for 12 bit times -> break_o one pulse, no valid_o; no new frame accepted until after 16 clk of high.
//  rst_ni low mid-DATA with valid_o high -> all outputs 0 asynchronously; next clean frame received correctly.

Source files
------------

// File: rtl/uart_rx_recovery_pkg.sv
// uart_rx_recovery_pkg: shared state, parity-mode encodings and config helpers for the UART receiver
package uart_rx_recovery_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_e;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_EVEN  = 3'd1;
  localparam logic [2:0] PAR_ODD   = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  localparam logic [3:0] MIN_DATA_BITS = 4'd5;

  function automatic logic [3:0] clamp_bits(input logic [3:0] req, input logic [3:0] max_bits);
    return (req < MIN_DATA_BITS) ? MIN_DATA_BITS : ((req > max_bits) ? max_bits : req);
  endfunction

  // unknown modes fall back to no parity
  function automatic logic [2:0] norm_parity(input logic [2:0] mode);
    return (mode > PAR_SPACE) ? PAR_NONE : mode;
  endfunction

  function automatic logic parity_bad(input logic [2:0] mode, input logic data_xor, input logic bit_in);
    return (mode == PAR_EVEN)  ? (data_xor ^ bit_in) :
           (mode == PAR_ODD)   ? ~(data_xor ^ bit_in) :
           (mode == PAR_MARK)  ? ~bit_in :
           (mode == PAR_SPACE) ? bit_in : 1'b0;
  endfunction

endpackage

// File: rtl/uart_rx_recovery_sync_filter.sv
// uart_rx_recovery_sync_filter: rx synchroniser, 3-sample history, majority vote and falling-edge detect
module uart_rx_recovery_sync_filter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic rx_s_o,
  output logic maj_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [2:0]             hist_q, hist_d;

  // shift the raw line through the synchroniser and the synchronised line into the history
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx_i};
    hist_d = {hist_q[1:0], sync_q[SYNC_STAGES-1]};
  end

  // idle-high reset so a line held high never looks like a start edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
      hist_q <= '1;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign rx_s_o = sync_q[SYNC_STAGES-1];
  assign maj_o  = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  assign fall_o = hist_q[0] & ~rx_s_o;

endmodule

// File: rtl/uart_rx_recovery.sv
// uart_rx_recovery: oversampled UART receiver with runtime framing, break/overrun detection and holding register
module uart_rx_recovery
  import uart_rx_recovery_pkg::*;
#(
  parameter int OVERSAMPLING  = 16,
  parameter int MAX_DATA_BITS = 9,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     rx_i,
  input  logic [3:0]               data_bits_i,
  input  logic [2:0]               parity_mode_i,
  input  logic                     stop_bits_i,
  output logic [MAX_DATA_BITS-1:0] char_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     frame_error_o,
  output logic                     parity_error_o,
  output logic                     overrun_o,
  output logic                     break_o,
  output logic                     busy_o
);

  localparam int                CW       = $clog2(OVERSAMPLING);
  localparam logic [CW-1:0]     HALF_BIT = CW'(OVERSAMPLING / 2 - 1);
  localparam logic [CW-1:0]     FULL_BIT = CW'(OVERSAMPLING - 1);
  localparam logic [3:0]        MAX_BITS = 4'(MAX_DATA_BITS);

  logic rx_s, maj, fall, mid;

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [3:0]               nbits_q, nbits_d, idx_q, idx_d;
  logic [2:0]               pmode_q, pmode_d;
  logic                     two_stop_q, two_stop_d, second_q, second_d;
  logic [MAX_DATA_BITS-1:0] shift_q, shift_d, char_q, char_d;
  logic                     par_q, par_d, zero_q, zero_d;
  logic                     ferr_acc_q, ferr_acc_d, perr_acc_q, perr_acc_d;
  logic                     valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d;
  logic                     ovr_q, ovr_d, brk_q, brk_d;

  uart_rx_recovery_sync_filter #(.SYNC_STAGES(SYNC_STAGES)) u_filter (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .rx_i  (rx_i),
    .rx_s_o(rx_s),
    .maj_o (maj),
    .fall_o(fall)
  );

  assign mid = (cnt_q == '0);

  // frame FSM, bit timing, shift/parity accumulation and holding-register update
  always_comb begin
    state_d    = state_q;
    cnt_d      = mid ? FULL_BIT : cnt_q - 1'b1;
    nbits_d    = nbits_q;
    idx_d      = idx_q;
    pmode_d    = pmode_q;
    two_stop_d = two_stop_q;
    second_d   = second_q;
    shift_d    = shift_q;
    par_d      = par_q;
    zero_d     = zero_q;
    ferr_acc_d = ferr_acc_q;
    perr_acc_d = perr_acc_q;
    char_d     = char_q;
    valid_d    = valid_q;
    ferr_d     = ferr_q;
    perr_d     = perr_q;
    ovr_d      = 1'b0;
    brk_d      = 1'b0;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      perr_d  = 1'b0;
    end
    case (state_q)
      ST_IDLE: if (fall) begin
        state_d    = ST_START;
        cnt_d      = HALF_BIT;
        nbits_d    = clamp_bits(data_bits_i, MAX_BITS);
        pmode_d    = norm_parity(parity_mode_i);
        two_stop_d = stop_bits_i;
        second_d   = 1'b0;
        idx_d      = 4'd0;
        shift_d    = '0;
        par_d      = 1'b0;
        zero_d     = 1'b1;
        ferr_acc_d = 1'b0;
        perr_acc_d = 1'b0;
      end
      ST_START: if (mid) state_d = maj ? ST_IDLE : ST_DATA;
      ST_DATA: if (mid) begin
        shift_d = shift_q | (MAX_DATA_BITS'(maj) << idx_q);
        par_d   = par_q ^ maj;
        zero_d  = zero_q & ~maj;
        idx_d   = idx_q + 4'd1;
        if (idx_q == nbits_q - 4'd1) state_d = (pmode_q == PAR_NONE) ? ST_STOP : ST_PARITY;
      end
      ST_PARITY: if (mid) begin
        perr_acc_d = parity_bad(pmode_q, par_q, maj);
        zero_d     = zero_q & ~maj;
        state_d    = ST_STOP;
      end
      ST_STOP: if (mid) begin
        ferr_acc_d = ferr_acc_q | ~maj;
        zero_d     = zero_q & ~maj;
        second_d   = 1'b1;
        if (!two_stop_q || second_q) begin
          if (zero_q && !maj) begin
            state_d = ST_BREAK;
            brk_d   = 1'b1;
            cnt_d   = FULL_BIT;
          end else begin
            state_d = ST_IDLE;
            if (!valid_q || ready_i) begin
              valid_d = 1'b1;
              char_d  = shift_q;
              ferr_d  = ferr_acc_q | ~maj;
              perr_d  = perr_acc_q;
            end else begin
              ovr_d = 1'b1;
            end
          end
        end
      end
      ST_BREAK: begin
        cnt_d = rx_s ? cnt_q - 1'b1 : FULL_BIT;
        if (rx_s && mid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state register; reset drops any frame in progress and any held character
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      nbits_q    <= MIN_DATA_BITS;
      idx_q      <= '0;
      pmode_q    <= PAR_NONE;
      two_stop_q <= 1'b0;
      second_q   <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      zero_q     <= 1'b0;
      ferr_acc_q <= 1'b0;
      perr_acc_q <= 1'b0;
      char_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nbits_q    <= nbits_d;
      idx_q      <= idx_d;
      pmode_q    <= pmode_d;
      two_stop_q <= two_stop_d;
      second_q   <= second_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      zero_q     <= zero_d;
      ferr_acc_q <= ferr_acc_d;
      perr_acc_q <= perr_acc_d;
      char_q     <= char_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      ovr_q      <= ovr_d;
      brk_q      <= brk_d;
    end
  end

  assign char_o         = char_q;
  assign valid_o        = valid_q;
  assign frame_error_o  = ferr_q;
  assign parity_error_o = perr_q;
  assign overrun_o      = ovr_q;
  assign break_o        = brk_q;
  assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_recovery.sv
// tb_uart_rx_recovery: directed and randomized frames checked against a frame-level reference model
module tb_uart_rx_recovery;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic       rx_i = 1'b1;
  logic       ready_i = 1'b1;
  logic [3:0] data_bits_i = 4'd8;
  logic [2:0] parity_mode_i = 3'd0;
  logic       stop_bits_i = 1'b0;
  logic [8:0] char_o;
  logic       valid_o, frame_error_o, parity_error_o, overrun_o, break_o, busy_o;

  int errors = 0;
  int checks = 0;
  int rd = 0;
  int ovr_cnt = 0;
  int brk_cnt = 0;
  logic [10:0] rxq[$];

  uart_rx_recovery dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rx_i          (rx_i),
    .data_bits_i   (data_bits_i),
    .parity_mode_i (parity_mode_i),
    .stop_bits_i   (stop_bits_i),
    .char_o        (char_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .frame_error_o (frame_error_o),
    .parity_error_o(parity_error_o),
    .overrun_o     (overrun_o),
    .break_o       (break_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // record every accepted transfer and count overrun/break pulses
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (valid_o && ready_i) rxq.push_back({frame_error_o, parity_error_o, char_o});
      ovr_cnt += int'(overrun_o);
      brk_cnt += int'(break_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_rx(input string tag, input logic [8:0] ch, input logic fe, input logic pe);
    logic [10:0] got;
    check({tag, "_count"}, 32'(rxq.size() - rd), 32'd1);
    got = (rxq.size() > rd) ? rxq[rd] : 11'bx;
    rd = rxq.size();
    check({tag, "_char"}, 32'(got[8:0]), 32'(ch));
    check({tag, "_ferr"}, 32'(got[10]), 32'(fe));
    check({tag, "_perr"}, 32'(got[9]), 32'(pe));
  endtask

  // reference: builds the line bits for one frame and what the receiver should report
  task automatic make_frame(input logic [8:0] data, input logic [3:0] raw, input logic [2:0] pm,
                            input logic two, input logic flip, input logic [1:0] slow,
                            output logic [15:0] v, output int len, output logic [8:0] ch,
                            output logic fe, output logic pe, output logic brk);
    int   n;
    logic p, has_par;
    n       = (raw < 4'd5) ? 5 : (raw > 4'd9) ? 9 : int'(raw);
    ch      = data & 9'((1 << n) - 1);
    has_par = (pm >= 3'd1) && (pm <= 3'd4);
    p       = (pm == 3'd1) ? ^ch : (pm == 3'd2) ? ~^ch : (pm == 3'd3);
    p       = p ^ flip;
    v       = 16'hFFFF;
    v[0]    = 1'b0;
    len     = 1;
    for (int i = 0; i < n; i++) begin
      v[len] = ch[i];
      len++;
    end
    if (has_par) begin
      v[len] = p;
      len++;
    end
    v[len] = ~slow[0];
    len++;
    if (two) begin
      v[len] = ~slow[1];
      len++;
    end
    pe  = has_par && flip;
    fe  = slow[0] || (two && slow[1]);
    brk = (ch == 9'd0) && (!has_par || !p) && slow[0] && (!two || slow[1]);
  endtask

  task automatic drive(input logic [15:0] v, input int len, input int gbit, input int goff, input logic scramble);
    for (int i = 0; i < len; i++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk_i);
        rx_i = (i == gbit && c == goff) ? ~v[i] : v[i];
      end
      if (scramble && i == 0) begin
        data_bits_i   = 4'($urandom);
        parity_mode_i = 3'($urandom);
        stop_bits_i   = 1'($urandom);
      end
    end
  endtask

  task automatic idle(input int bits);
    rx_i = 1'b1;
    repeat (16 * bits) @(negedge clk_i);
  endtask

  task automatic set_cfg(input logic [3:0] nb, input logic [2:0] pm, input logic two);
    data_bits_i   = nb;
    parity_mode_i = pm;
    stop_bits_i   = two;
  endtask

  initial begin
    logic [15:0] v;
    int          len, o0, b0;
    logic [8:0]  ch, rdata;
    logic        fe, pe, brk, two, flip;
    logic [3:0]  raw;
    logic [2:0]  pm;
    logic [1:0]  slow;

    #2 rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_char", 32'(char_o), 32'd0);
    check("rst_ferr", 32'(frame_error_o), 32'd0);
    check("rst_perr", 32'(parity_error_o), 32'd0);
    check("rst_ovr", 32'(overrun_o), 32'd0);
    check("rst_brk", 32'(break_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    rst_ni = 1'b1;
    idle(2);

    set_cfg(4'd8, 3'd0, 1'b0);
    make_frame(9'h0A5, 4'd8, 3'd0, 1'b0, 1'b0, 2'b00, v, len, ch, fe, pe, brk);
    drive(v, len, -1, 0, 1'b0);
    idle(2);
    expect_rx("8n1_a5", 9'h0A5, 1'b0, 1'b0);

    set_cfg(4'd7, 3'd1, 1'b1);
    make_frame(9'h041, 4'd7, 3'd1, 1'b1, 1'b1, 2'b00, v, len, ch, fe, pe, brk);
    drive(v, len, -1, 0, 1'b0);
    idle(2);
    expect_rx("7e2_par", 9'h041, 1'b0, 1'b1);
    make_frame(9'h041, 4'd7, 3'd1, 1'b1, 1'b0, 2'b10, v, len, ch, fe, pe, brk);
    drive(v, len, -1, 0, 1'b0);
    idle(2);
    expect_rx("7e2_stop", 9'h041, 1'b1, 1'b0);

    set_cfg(4'd8, 3'd0, 1'b0);
    @(negedge clk_i) rx_i = 1'b0;
    @(negedge clk_i) rx_i = 1'b1;
    idle(2);
    rx_i = 1'b0;
    repeat (2) @(negedge clk_i);
    idle(2);
    check("glitch_none", 32'(rxq.size() - rd), 32'd0);
    check("glitch_busy", 32'(busy_o), 32'd0);
    make_frame(9'h05A, 4'd8, 3'd0, 1'b0, 1'b0, 2'b00, v, len, ch, fe, pe, brk);
    drive(v, len, 4, 6, 1'b0);
    idle(2);
    expect_rx("glitch_frame", 9'h05A, 1'b0, 1'b0);

    o0 = ovr_cnt;
    for (int k = 0; k < 10; k++) begin
      rdata = 9'($urandom);
      raw   = 4'($urandom_range(3, 11));
      pm    = 3'($urandom_range(0, 7));
      two   = 1'($urandom);
      flip  = ($urandom_range(0, 3) == 0);
      slow  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      if (k == 9) begin
        rdata = 9'd0;
        pm    = 3'd4;
        flip  = 1'b0;
        slow  = 2'b11;
      end
      set_cfg(raw, pm, two);
      make_frame(rdata, raw, pm, two, flip, slow, v, len, ch, fe, pe, brk);
      b0 = brk_cnt;
      drive(v, len, -1, 0, 1'b1);
      idle(3);
      if (brk) begin
        check("rand_brk_pulse", 32'(brk_cnt - b0), 32'd1);
        check("rand_brk_nochar", 32'(rxq.size() - rd), 32'd0);
      end else begin
        expect_rx("rand", ch, fe, pe);
      end
    end
    check("rand_no_ovr", 32'(ovr_cnt - o0), 32'd0);

    set_cfg(4'd8, 3'd0, 1'b0);
    @(posedge clk_i);
    #1 ready_i = 1'b0;
    o0 = ovr_cnt;
    make_frame(9'h011, 4'd8, 3'd0, 1'b0, 1'b0, 2'b00, v, len, ch, fe, pe, brk);
    drive(v, len, -1, 0, 1'b0);
    make_frame(9'h022, 4'd8, 3'd0, 1'b0, 1'b0, 2'b00, v, len, ch, fe, pe, brk);
    drive(v, len, -1, 0, 1'b0);
    idle(2);
    check("b2b_valid", 32'(valid_o), 32'd1);
    check("b2b_char", 32'(char_o), 32'h011);
    check("b2b_ovr", 32'(ovr_cnt - o0), 32'd1);
    @(posedge clk_i);
    #1 ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("b2b_valid_fall", 32'(valid_o), 32'd0);
    expect_rx("b2b_xfer", 9'h011, 1'b0, 1'b0);

    b0 = brk_cnt;
    @(negedge clk_i) rx_i = 1'b0;
    repeat (192) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (10) @(negedge clk_i);
    check("brk_pulse", 32'(brk_cnt - b0), 32'd1);
    check("brk_hold_busy", 32'(busy_o), 32'd1);
    repeat (12) @(negedge clk_i);
    check("brk_released", 32'(busy_o), 32'd0);
    check("brk_nochar", 32'(rxq.size() - rd), 32'd0);
    check("brk_novalid", 32'(valid_o), 32'd0);

    @(posedge clk_i);
    #1 ready_i = 1'b0;
    make_frame(9'h033, 4'd8, 3'd0, 1'b0, 1'b0, 2'b00, v, len, ch, fe, pe, brk);
    drive(v, len, -1, 0, 1'b0);
    idle(1);
    check("hold_valid", 32'(valid_o), 32'd1);
    make_frame(9'h044, 4'd8, 3'd0, 1'b0, 1'b0, 2'b00, v, len, ch, fe, pe, brk);
    drive(v, 4, -1, 0, 1'b0);
    check("mid_busy", 32'(busy_o), 32'd1);
    #2 rst_ni = 1'b0;
    rx_i = 1'b1;
    #1;
    check("async_valid", 32'(valid_o), 32'd0);
    check("async_char", 32'(char_o), 32'd0);
    check("async_busy", 32'(busy_o), 32'd0);
    ready_i = 1'b1;
    @(negedge clk_i) rst_ni = 1'b1;
    idle(2);
    make_frame(9'h03C, 4'd8, 3'd0, 1'b0, 1'b0, 2'b00, v, len, ch, fe, pe, brk);
    drive(v, len, -1, 0, 1'b0);
    idle(2);
    expect_rx("post_reset", 9'h03C, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
